// File: rtl/lut_config_pkg.sv
// Shared types and sizing helpers for the LUT configuration loader.
package lut_config_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of stream chunks that make up one truth table.
    function automatic int calc_chunks(input int mem_size, input int config_width);
        return mem_size / config_width;
    endfunction

    // Counter width for n values, never narrower than one bit.
    function automatic int width_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lut_config_assembler.sv
// Collects CONFIG_WIDTH chunks LSB-first into one MEM_SIZE truth-table word.
module lut_config_assembler
    import lut_config_pkg::*;
#(
    parameter int MEM_SIZE     = 16,
    parameter int CONFIG_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic                    clr,
    input  logic [CONFIG_WIDTH-1:0] chunk,
    output logic [MEM_SIZE-1:0]     word,
    output logic                    last
);

    localparam int CHUNKS = calc_chunks(MEM_SIZE, CONFIG_WIDTH);
    localparam int CNT_W  = width_min1(CHUNKS);

    logic [CNT_W-1:0] cnt;

    // The chunk being written now completes the word.
    assign last = (cnt == CNT_W'(CHUNKS - 1));

    // Place each accepted chunk at its slot; counter wraps after the final chunk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            word <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wr) begin
            word[cnt*CONFIG_WIDTH +: CONFIG_WIDTH] <= chunk;
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lut_config_loader.sv
// Streams truth tables into a LUT bank: assemble, then one-cycle config_en per LUT.
module lut_config_loader
    import lut_config_pkg::*;
#(
    parameter int INPUTS       = 4,
    parameter int MEM_SIZE     = 2**INPUTS,
    parameter int CONFIG_WIDTH = 4,
    parameter int NUM_LUTS     = 4
) (
    input  logic                    config_clk,
    input  logic                    config_rst,
    input  logic                    start,
    input  logic [CONFIG_WIDTH-1:0] data_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic [NUM_LUTS-1:0]     config_en,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = width_min1(NUM_LUTS);

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     lut_idx;
    logic [MEM_SIZE-1:0]  word;
    logic [MEM_SIZE-1:0]  held;
    logic                 last_chunk;
    logic                 accept;
    logic                 asm_clr;
    logic                 lut_last;

    assign accept   = (state == LOAD) && data_valid;
    assign asm_clr  = (state == IDLE);
    assign lut_last = (lut_idx == IDX_W'(NUM_LUTS - 1));

    lut_config_assembler #(
        .MEM_SIZE     (MEM_SIZE),
        .CONFIG_WIDTH (CONFIG_WIDTH)
    ) u_asm (
        .clk   (config_clk),
        .rst   (config_rst),
        .wr    (accept),
        .clr   (asm_clr),
        .chunk (data_in),
        .word  (word),
        .last  (last_chunk)
    );

    // State register.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next state and state-decoded outputs; nothing here looks at data_valid/start
    // except the transition itself, so outputs never depend combinationally on inputs.
    always_comb begin
        state_nxt  = state;
        data_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        config_en  = '0;
        config_out = held;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = LOAD;
            end
            LOAD: begin
                data_ready = 1'b1;
                if (accept && last_chunk) state_nxt = COMMIT;
            end
            COMMIT: begin
                config_out         = word;
                config_en[lut_idx] = 1'b1;
                state_nxt          = lut_last ? DONE : LOAD;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // LUT index: cleared while idle, advanced after each non-final commit.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst)                        lut_idx <= '0;
        else if (state == IDLE)                lut_idx <= '0;
        else if (state == COMMIT && !lut_last) lut_idx <= lut_idx + 1'b1;
    end

    // Keep the last committed word on the bus between commits.
    always_ff @(posedge config_clk or posedge config_rst) begin
        if (config_rst)            held <= '0;
        else if (state == COMMIT)  held <= word;
    end

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench: 4-chunk/2-LUT instance plus a single-chunk/3-LUT instance.
module tb_lut_config_loader;

    logic        config_clk = 1'b0;
    logic        config_rst;
    always #5 config_clk = ~config_clk;

    // Instance A: INPUTS=4, CONFIG_WIDTH=4, NUM_LUTS=2
    logic        start, data_valid, data_ready, busy, done;
    logic [3:0]  data_in;
    logic [15:0] config_out;
    logic [1:0]  config_en;

    // Instance B: CONFIG_WIDTH=16, NUM_LUTS=3
    logic        b_start, b_data_valid, b_data_ready, b_busy, b_done;
    logic [15:0] b_data_in;
    logic [15:0] b_config_out;
    logic [2:0]  b_config_en;

    lut_config_loader #(.INPUTS(4), .CONFIG_WIDTH(4), .NUM_LUTS(2)) u_dut (
        .config_clk (config_clk), .config_rst (config_rst), .start (start),
        .data_in (data_in), .data_valid (data_valid), .data_ready (data_ready),
        .config_out (config_out), .config_en (config_en), .busy (busy), .done (done)
    );

    lut_config_loader #(.INPUTS(4), .CONFIG_WIDTH(16), .NUM_LUTS(3)) u_dut_b (
        .config_clk (config_clk), .config_rst (config_rst), .start (b_start),
        .data_in (b_data_in), .data_valid (b_data_valid), .data_ready (b_data_ready),
        .config_out (b_config_out), .config_en (b_config_en), .busy (b_busy), .done (b_done)
    );

    int checks = 0;
    int errors = 0;

    logic [1:0]  en_q[$];
    logic [15:0] out_q[$];
    logic [2:0]  b_en_q[$];
    logic [15:0] b_out_q[$];
    logic [3:0]  ch[8];
    time         start_t;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Record every config_en pulse with the bus value seen alongside it.
    always @(negedge config_clk) begin
        if (config_en != 0) begin
            en_q.push_back(config_en);
            out_q.push_back(config_out);
            chk("a_rdy_in_commit", {31'd0, data_ready}, 32'd0);
        end
        if (b_config_en != 0) begin
            b_en_q.push_back(b_config_en);
            b_out_q.push_back(b_config_out);
            chk("b_rdy_in_commit", {31'd0, b_data_ready}, 32'd0);
        end
    end

    task automatic do_start_a();
        @(negedge config_clk);
        chk("a_idle_before_start", {31'd0, busy}, 32'd0);
        start   = 1'b1;
        start_t = $time;
        @(negedge config_clk);
        start = 1'b0;
        chk("a_load_entry_rdy", {31'd0, data_ready}, 32'd1);
    endtask

    task automatic feed_a(input int n, input bit stall, input int start_at);
        int idx = 0;
        int it  = 0;
        bit tog = 1'b0;
        bit rdy;
        while (idx < n && it < 200) begin
            data_in    = ch[idx];
            data_valid = stall ? tog : 1'b1;
            tog        = ~tog;
            start      = (it == start_at);
            rdy        = data_ready;
            @(posedge config_clk);
            if (data_valid && rdy) idx++;
            @(negedge config_clk);
            it++;
        end
        data_valid = 1'b0;
        start      = 1'b0;
        chk("a_feed_accepted", idx, n);
    endtask

    task automatic wait_done_a(output int ncyc);
        bit found = 1'b0;
        ncyc = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge config_clk);
            if (done) begin
                found = 1'b1;
                ncyc  = int'(($time - start_t) / 10) + 1;
            end
        end
        chk("a_done_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic run_load_a(input bit stall, input int start_at, output int ncyc);
        do_start_a();
        feed_a(8, stall, start_at);
        wait_done_a(ncyc);
    endtask

    task automatic chk_commits_a(input string tag, input logic [15:0] w0, input logic [15:0] w1);
        chk({tag, "_ncommit"}, en_q.size(), 2);
        if (en_q.size() == 2) begin
            chk({tag, "_en0"},  {30'd0, en_q[0]}, 32'd1);
            chk({tag, "_out0"}, {16'd0, out_q[0]}, {16'd0, w0});
            chk({tag, "_en1"},  {30'd0, en_q[1]}, 32'd2);
            chk({tag, "_out1"}, {16'd0, out_q[1]}, {16'd0, w1});
        end
        en_q.delete();
        out_q.delete();
    endtask

    initial begin
        int n_basic, n_stall, n;
        bit found;
        logic [15:0] bw[3];

        config_rst   = 1'b1;
        start        = 1'b0; data_valid   = 1'b0; data_in   = '0;
        b_start      = 1'b0; b_data_valid = 1'b0; b_data_in = '0;
        repeat (2) @(negedge config_clk);
        chk("rst_ready",  {31'd0, data_ready}, 32'd0);
        chk("rst_en",     {30'd0, config_en}, 32'd0);
        chk("rst_out",    {16'd0, config_out}, 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_done",   {31'd0, done}, 32'd0);
        config_rst = 1'b0;

        // Basic load, data_valid held high.
        ch = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_load_a(1'b0, -1, n_basic);
        chk("basic_done_cycles", n_basic, 12);
        chk_commits_a("basic", 16'h4321, 16'h8765);

        // Back-to-back: start in the first IDLE cycle after done.
        ch = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
        run_load_a(1'b0, -1, n);
        chk("b2b_done_cycles", n, 12);
        chk_commits_a("b2b", 16'h3210, 16'h7654);

        // Stalls on alternating cycles.
        ch = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
        run_load_a(1'b1, -1, n_stall);
        chk("stall_later", {31'd0, n_stall > n_basic}, 32'd1);
        chk_commits_a("stall", 16'h4321, 16'h8765);
        @(negedge config_clk);
        chk("idle_holds_out", {16'd0, config_out}, 32'h8765);
        chk("idle_no_en", {30'd0, config_en}, 32'd0);

        // data_valid in IDLE is not consumed; start during LOAD is ignored.
        data_valid = 1'b1; data_in = 4'hF;
        repeat (3) begin
            @(negedge config_clk);
            chk("idle_valid_rdy", {31'd0, data_ready}, 32'd0);
        end
        data_valid = 1'b0;
        run_load_a(1'b0, 2, n);
        chk("ign_done_cycles", n, 12);
        chk_commits_a("ignored", 16'h4321, 16'h8765);

        // Reset after two chunks of LUT 0.
        do_start_a();
        feed_a(2, 1'b0, -1);
        #2 config_rst = 1'b1;
        #1;
        chk("mrst_ready", {31'd0, data_ready}, 32'd0);
        chk("mrst_busy",  {31'd0, busy}, 32'd0);
        chk("mrst_out",   {16'd0, config_out}, 32'd0);
        chk("mrst_en",    {30'd0, config_en}, 32'd0);
        chk("mrst_done",  {31'd0, done}, 32'd0);
        repeat (3) @(negedge config_clk);
        config_rst = 1'b0;
        chk("mrst_no_pulse", en_q.size(), 0);
        ch = '{4'h9, 4'hA, 4'hB, 4'hC, 4'h1, 4'h2, 4'h3, 4'h4};
        run_load_a(1'b0, -1, n);
        chk_commits_a("mrst_fresh", 16'hCBA9, 16'h4321);

        // Single-chunk corner on instance B.
        bw = '{16'hBEEF, 16'h0001, 16'hFFFF};
        @(negedge config_clk);
        b_start = 1'b1;
        start_t = $time;
        @(negedge config_clk);
        b_start = 1'b0;
        begin
            int idx = 0;
            int it  = 0;
            bit rdy;
            while (idx < 3 && it < 100) begin
                b_data_in    = bw[idx];
                b_data_valid = 1'b1;
                rdy          = b_data_ready;
                @(posedge config_clk);
                if (rdy) idx++;
                @(negedge config_clk);
                it++;
            end
            b_data_valid = 1'b0;
            chk("b_feed_accepted", idx, 3);
        end
        found = 1'b0;
        n = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (b_done) begin
                found = 1'b1;
                n = int'(($time - start_t) / 10) + 1;
            end else begin
                @(negedge config_clk);
            end
        end
        chk("b_done_seen", {31'd0, found}, 32'd1);
        chk("b_done_cycles", n, 8);
        chk("b_ncommit", b_en_q.size(), 3);
        if (b_en_q.size() == 3) begin
            chk("b_en0", {29'd0, b_en_q[0]}, 32'd1);
            chk("b_out0", {16'd0, b_out_q[0]}, 32'hBEEF);
            chk("b_en1", {29'd0, b_en_q[1]}, 32'd2);
            chk("b_out1", {16'd0, b_out_q[1]}, 32'h0001);
            chk("b_en2", {29'd0, b_en_q[2]}, 32'd4);
            chk("b_out2", {16'd0, b_out_q[2]}, 32'hFFFF);
        end
        @(negedge config_clk);
        chk("b_idle_busy", {31'd0, b_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
